// File: rtl/rv32m_pkg.sv
// rtl/rv32m_pkg.sv - shared RV32M op codes, widths and divider FSM state type
//
// Purpose: common definitions for the RV32M execution blocks (alu_m_extension
//          and rv32m_div_unit). Holds XLEN, the alu_control codes for the MUL
//          and DIV families, the divider state enum and small op decode helpers.
// Ports:   none (package).
package rv32m_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] OP_MUL    = 5'b01000;
  localparam logic [4:0] OP_MULH   = 5'b01001;
  localparam logic [4:0] OP_MULHU  = 5'b01010;
  localparam logic [4:0] OP_MULHSU = 5'b01011;
  localparam logic [4:0] OP_DIV    = 5'b01100;
  localparam logic [4:0] OP_DIVU   = 5'b01101;
  localparam logic [4:0] OP_REM    = 5'b01110;
  localparam logic [4:0] OP_REMU   = 5'b01111;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_signed_op(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem_op(input logic [4:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/rv32m_div_unit_if.sv
// rtl/rv32m_div_unit_if.sv - EX-stage request/response bundle for the divider
//
// Purpose: groups the divider request (start/flush/op/operands) and response
//          (result/done/busy/stall) signals.
// Ports (signals):
//   start, flush        request / pipeline kill          (master -> slave)
//   alu_control [4:0]   op select                        (master -> slave)
//   data1, data2        dividend / divisor               (master -> slave)
//   result              quotient or remainder            (slave -> master)
//   done, busy, stall   completion pulse, in-flight, hazard stall (slave -> master)
interface rv32m_div_unit_if;
  import rv32m_pkg::*;

  logic            start;
  logic            flush;
  logic [4:0]      alu_control;
  logic [XLEN-1:0] data1;
  logic [XLEN-1:0] data2;
  logic [XLEN-1:0] result;
  logic            done;
  logic            busy;
  logic            stall;

  modport master (
    output start, flush, alu_control, data1, data2,
    input  result, done, busy, stall
  );

  modport slave (
    input  start, flush, alu_control, data1, data2,
    output result, done, busy, stall
  );

endinterface

// File: rtl/rv32m_div_step.sv
// rtl/rv32m_div_step.sv - one restoring-division iteration (combinational)
//
// Purpose: shifts {rem, quo} left by one, trial-subtracts the divisor from the
//          widened partial remainder and sets the new quotient bit.
// Ports:
//   rem_in   in   XLEN  partial remainder (always < divisor)
//   quo_in   in   XLEN  dividend bits not yet consumed / quotient bits so far
//   divisor  in   XLEN  magnitude of the divisor
//   rem_out  out  XLEN  next partial remainder
//   quo_out  out  XLEN  next quotient/dividend shift register
module rv32m_div_step
  import rv32m_pkg::*;
(
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          fits;

  assign shifted = {rem_in, quo_in[XLEN-1]};
  assign diff    = shifted - {1'b0, divisor};
  // rem_in < divisor, so shifted < 2*divisor: a non-negative difference always
  // fits in XLEN bits and a borrow always sets the top bit.
  assign fits    = ~diff[XLEN];

  always_comb begin
    rem_out = shifted[XLEN-1:0];
    quo_out = {quo_in[XLEN-2:0], 1'b0};
    if (fits) begin
      rem_out    = diff[XLEN-1:0];
      quo_out[0] = 1'b1;
    end
  end

endmodule

// File: rtl/rv32m_div_unit.sv
// rtl/rv32m_div_unit.sv - iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU
//
// Purpose: captures operands on an accepted start, runs 32 restoring steps,
//          applies sign fix-up and presents a registered result with a one
//          cycle done pulse. Divide-by-zero and signed overflow finish in one
//          cycle with the architectural results. Raises stall while in flight.
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   div_if  slave modport: start, flush, alu_control, data1, data2 in;
//           result, done, busy, stall out
module rv32m_div_unit
  import rv32m_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  rv32m_div_unit_if.slave div_if
);

  div_state_e      state_q, state_d;
  logic [5:0]      count_q;
  logic [XLEN-1:0] rem_q, quo_q, divisor_q, result_q;
  logic            neg_quo_q, neg_rem_q, rem_op_q;

  logic            valid_op, accept, signed_op, rem_op;
  logic            a_neg, b_neg, div_zero, overflow, special;
  logic [XLEN-1:0] abs_a, abs_b, special_val;
  logic [XLEN-1:0] step_rem, step_quo;
  logic [XLEN-1:0] quo_fix, rem_fix, fix_val;
  logic            done, busy;

  // ---------------- request decode ----------------
  assign valid_op  = is_div_op(div_if.alu_control);
  assign signed_op = is_signed_op(div_if.alu_control);
  assign rem_op    = is_rem_op(div_if.alu_control);
  // flush wins over a same-cycle start
  assign accept    = (state_q == DIV_IDLE) && div_if.start && valid_op && !div_if.flush;

  assign a_neg = signed_op & div_if.data1[XLEN-1];
  assign b_neg = signed_op & div_if.data2[XLEN-1];
  assign abs_a = a_neg ? -div_if.data1 : div_if.data1;
  assign abs_b = b_neg ? -div_if.data2 : div_if.data2;

  assign div_zero = (div_if.data2 == '0);
  assign overflow = signed_op && (div_if.data1 == {1'b1, {(XLEN-1){1'b0}}})
                              && (div_if.data2 == '1);
  assign special  = div_zero | overflow;

  always_comb begin
    special_val = '0;
    if (div_zero) begin
      special_val = rem_op ? div_if.data1 : '1;
    end else if (overflow) begin
      special_val = rem_op ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // ---------------- datapath ----------------
  rv32m_div_step u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (divisor_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  assign quo_fix = neg_quo_q ? -quo_q : quo_q;
  assign rem_fix = neg_rem_q ? -rem_q : rem_q;
  assign fix_val = rem_op_q ? rem_fix : quo_fix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_op_q  <= 1'b0;
      result_q  <= '0;
    end else if (accept) begin
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= abs_a;
      divisor_q <= abs_b;
      neg_quo_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      rem_op_q  <= rem_op;
      // special cases skip the iteration and publish straight from the inputs
      if (special) begin
        result_q <= special_val;
      end
    end else if (state_q == DIV_CALC) begin
      rem_q   <= step_rem;
      quo_q   <= step_quo;
      count_q <= count_q + 6'd1;
    end else if ((state_q == DIV_FIX) && !div_if.flush) begin
      result_q <= fix_val;
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_IDLE: if (accept) state_d = special ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (count_q == 6'd31) state_d = DIV_FIX;
      DIV_FIX:  state_d = DIV_DONE;
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
    if (div_if.flush && (state_q != DIV_IDLE)) begin
      state_d = DIV_IDLE;
    end
  end

  always_comb begin
    done = (state_q == DIV_DONE);
    busy = (state_q != DIV_IDLE);
  end

  assign div_if.result = result_q;
  assign div_if.done   = done;
  assign div_if.busy   = busy;
  // request-side term lets the hazard unit freeze in the accept cycle itself
  assign div_if.stall  = (div_if.start & valid_op & ~done) | busy;

endmodule

// File: tb/tb_rv32m_div_unit.sv
// tb/tb_rv32m_div_unit.sv - directed self-checking bench for rv32m_div_unit
module tb_rv32m_div_unit;
  import rv32m_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  rv32m_div_unit_if dif ();

  rv32m_div_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .div_if (dif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one op, follow it to done, check latency/result, and poke a start
  // into the DONE cycle which must be ignored.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int   lat;
    logic hold_ok;
    dif.alu_control = op;
    dif.data1 = a;
    dif.data2 = b;
    dif.start = 1'b1;
    #1;
    check({tag, " stall_req"}, {31'd0, dif.stall}, 32'd1);
    tick;
    dif.start = 1'b0;
    dif.data1 = $urandom;
    dif.data2 = $urandom;
    lat = 1;
    hold_ok = 1'b1;
    while (dif.done !== 1'b1 && lat < 60) begin
      if (dif.busy !== 1'b1 || dif.stall !== 1'b1) hold_ok = 1'b0;
      tick;
      lat++;
    end
    check({tag, " done"}, {31'd0, dif.done}, 32'd1);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, dif.result, exp_res);
    check({tag, " busy_stall"}, {31'd0, hold_ok}, 32'd1);
    dif.alu_control = OP_DIVU;
    dif.data1 = 32'd50;
    dif.data2 = 32'd5;
    dif.start = 1'b1;
    tick;
    dif.start = 1'b0;
    check({tag, " done_pulse"}, {31'd0, dif.done}, 32'd0);
    check({tag, " no_accept_in_done"}, {31'd0, dif.busy}, 32'd0);
    check({tag, " result_hold"}, dif.result, exp_res);
  endtask

  initial begin
    int seen;
    dif.start = 1'b0;
    dif.flush = 1'b0;
    dif.alu_control = OP_MUL;
    dif.data1 = '0;
    dif.data2 = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset result", dif.result, 32'd0);
    check("reset done", {31'd0, dif.done}, 32'd0);
    check("reset busy", {31'd0, dif.busy}, 32'd0);
    check("reset stall", {31'd0, dif.stall}, 32'd0);
    rst_n = 1'b1;
    tick;

    // non-divide op is ignored and does not stall
    dif.alu_control = OP_MUL;
    dif.data1 = 32'd6;
    dif.data2 = 32'd3;
    dif.start = 1'b1;
    #1;
    check("mul stall", {31'd0, dif.stall}, 32'd0);
    tick;
    dif.start = 1'b0;
    check("mul busy", {31'd0, dif.busy}, 32'd0);

    run_op("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
    run_op("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
    run_op("divu_big",   OP_DIVU, 32'hFFFF_FFFF, 32'd16,        32'h0FFF_FFFF, 34);
    run_op("remu_big",   OP_REMU, 32'hFFFF_FFFF, 32'd16,        32'h0000_000F, 34);
    run_op("div_7_m2",   OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    run_op("rem_7_m2",   OP_REM,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 34);
    run_op("div_5_0",    OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run_op("rem_5_0",    OP_REM,  32'd5,         32'd0,         32'h0000_0005, 1);
    run_op("divu_0_0",   OP_DIVU, 32'd0,         32'd0,         32'hFFFF_FFFF, 1);
    run_op("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    run_op("divu_100_7", OP_DIVU, 32'd100,       32'd7,         32'd14,        34);

    // second start while busy is ignored; flush at cycle 10 aborts
    dif.alu_control = OP_DIV;
    dif.data1 = 32'd1000;
    dif.data2 = 32'd3;
    dif.start = 1'b1;
    tick;
    dif.start = 1'b0;
    repeat (4) tick;
    dif.alu_control = OP_DIV;
    dif.data1 = 32'd9;
    dif.data2 = 32'd0;
    dif.start = 1'b1;
    tick;
    dif.start = 1'b0;
    check("busy_after_2nd_start", {31'd0, dif.busy}, 32'd1);
    check("no_done_after_2nd_start", {31'd0, dif.done}, 32'd0);
    repeat (4) tick;
    dif.flush = 1'b1;
    tick;
    dif.flush = 1'b0;
    check("flush busy", {31'd0, dif.busy}, 32'd0);
    check("flush stall", {31'd0, dif.stall}, 32'd0);
    check("flush done", {31'd0, dif.done}, 32'd0);
    check("flush result_kept", dif.result, 32'd14);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (dif.done === 1'b1 || dif.busy === 1'b1) seen++;
      tick;
    end
    check("flush stays_idle", seen, 32'd0);

    // flush beats a same-cycle start in IDLE
    dif.alu_control = OP_DIVU;
    dif.data1 = 32'd20;
    dif.data2 = 32'd4;
    dif.start = 1'b1;
    dif.flush = 1'b1;
    tick;
    dif.start = 1'b0;
    dif.flush = 1'b0;
    check("flush_beats_start", {31'd0, dif.busy}, 32'd0);

    // asynchronous reset mid-divide
    dif.alu_control = OP_DIV;
    dif.data1 = 32'd100;
    dif.data2 = 32'd7;
    dif.start = 1'b1;
    tick;
    dif.start = 1'b0;
    repeat (11) tick;
    check("pre_reset busy", {31'd0, dif.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset busy", {31'd0, dif.busy}, 32'd0);
    check("async_reset done", {31'd0, dif.done}, 32'd0);
    check("async_reset result", dif.result, 32'd0);
    tick;
    rst_n = 1'b1;
    tick;
    run_op("div_100_7", OP_DIV, 32'd100, 32'd7, 32'd14, 34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
